func_eval_arbiter: RTL and testbench
====================================

Name: func_eval_arbiter

Overview:
Shares a single 2-input Boolean function evaluator between NUM_REQ requesters using round-robin arbitration and valid/ready handshakes. The function is a programmable 4-entry truth table. Its default is f=1 for x=2'b11 or x[1]=0, and f=0 otherwise. The block sequences each transaction through three phases: accept, registered evaluate, and hold response. It sits between requester logic and the shared function resource.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ID_W, $clog2(NUM_REQ), width of the requester index.
TRUTH_RST, 4'b1011, reset truth table; bit[i] is f for x==i.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  NUM_REQ  per-requester request valid.
req_x  input  2*NUM_REQ  operand; requester k uses bits [2k+1:2k].
req_ready  output  NUM_REQ  one-hot grant/accept, asserted for one cycle.
resp_valid  output  1  result valid.
resp_id  output  ID_W  index of the requester being answered.
resp_f  output  1  function result.
resp_ready  input  1  consumer accepts the result.
cfg_we  input  1  truth-table write enable.
cfg_truth  input  4  new truth table.
busy  output  1  high whenever state != IDLE.
served_cnt  output  8  completed-transaction counter; wraps from 255 to 0.

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - state=IDLE, rr_ptr=0, truth=TRUTH_RST.
  - resp_valid=0, resp_id=0, resp_f=0, served_cnt=0.
  - req_ready=0 and busy=0.
- An in-flight transaction is dropped on reset and produces no response.
- FSM states are IDLE, EVAL and RESP.
- IDLE:
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise grant g = the first set bit of req_valid, scanning from rr_ptr upward with wrap-around.
  - req_ready[g]=1 combinationally in this cycle. All other req_ready bits are 0.
  - At the clock edge: capture x_q=req_x[g] and id_q=g, set rr_ptr=(g+1) mod NUM_REQ, and go to EVAL.
- EVAL:
  - req_ready is all 0.
  - At the edge: resp_f<=truth[x_q], resp_id<=id_q, resp_valid<=1, go to RESP.
- RESP:
  - resp_valid, resp_id and resp_f hold stable until resp_ready=1.
  - On the edge where resp_valid && resp_ready: resp_valid<=0, served_cnt<=served_cnt+1, go to IDLE.
- Latency: accept at cycle t gives resp_valid at cycle t+2. Minimum spacing between accepts is 3 cycles.
- req_ready is asserted only in IDLE, so at most one bit is set at any time.
- Requesters must hold req_valid and req_x stable until they see their req_ready. Deasserting earlier is legal; the request is then simply not served.
- rr_ptr advances only on a grant. A lone requester is granted repeatedly.
- Truth-table configuration:
  - cfg_we loads truth<=cfg_truth at the edge, in any state.
  - An EVAL in the same cycle as cfg_we uses the old table. The new table applies from the next EVAL.
- resp_ready is ignored outside RESP.

Test Plan:
1. Reset with the default table. Requester 0 sends x=2'b00, 2'b01, 2'b10, 2'b11 in turn, with resp_ready held at 1. Required resp_f sequence is 1,1,0,1 with resp_id=0. Each resp_valid appears 2 cycles after the corresponding req_ready. served_cnt ends at 4.
2. All 4 req_valid held high, resp_ready=1. Required grant order is 0,1,2,3,0,1. req_ready is always one-hot, and resp_id follows the same order.
3. Only requesters 1 and 3 valid, rr_ptr=2 after prior traffic. Required grant order is 3,1,3.
4. Backpressure: resp_ready=0 for 5 cycles while in RESP with x=2'b10. resp_valid, resp_f=0 and resp_id must stay stable, and no req_ready may assert. Raising resp_ready for one cycle returns the FSM to IDLE and increments served_cnt.
5. In EVAL for x=2'b10, pulse cfg_we with cfg_truth=4'b0100. Required: this response gives f=0 from the old table. The next x=2'b10 request gives f=1.
6. Assert reset during EVAL. Required: resp_valid=0 immediately, busy=0, truth=4'b1011, served_cnt=0. No response is issued for the dropped request.

Source files
------------

// File: rtl/func_eval_arbiter.sv
// Round-robin arbiter sharing one programmable 2-input truth-table evaluator.
// Ports: clk/reset, req_valid/req_x/req_ready (requesters), resp_* (result), cfg_we/cfg_truth, busy, served_cnt.
module func_eval_arbiter #(
  parameter int         NUM_REQ   = 4,
  parameter int         ID_W      = $clog2(NUM_REQ),
  parameter logic [3:0] TRUTH_RST = 4'b1011
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_x,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 resp_valid,
  output logic [ID_W-1:0]      resp_id,
  output logic                 resp_f,
  input  logic                 resp_ready,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_truth,
  output logic                 busy,
  output logic [7:0]           served_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt;
  logic [ID_W-1:0] id_q;
  logic            hit;
  logic [1:0]      x_q;
  logic [3:0]      truth;

  // (base + off) mod NUM_REQ, for off in 0..NUM_REQ
  function automatic logic [ID_W-1:0] wrap_idx(
    input logic [ID_W-1:0] base,
    input int              off
  );
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // first valid requester at or after rr_ptr, wrapping around
  always_comb begin
    hit = 1'b0;
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && req_valid[wrap_idx(rr_ptr, i)]) begin
        hit = 1'b1;
        gnt = wrap_idx(rr_ptr, i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && hit) req_ready[gnt] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      truth      <= TRUTH_RST;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_f     <= 1'b0;
      served_cnt <= '0;
      x_q        <= '0;
      id_q       <= '0;
    end else begin
      // table reads below see the pre-edge value
      if (cfg_we) truth <= cfg_truth;
      unique case (state)
        IDLE: begin
          if (hit) begin
            x_q    <= req_x[{gnt, 1'b0} +: 2];
            id_q   <= gnt;
            rr_ptr <= wrap_idx(gnt, 1);
            state  <= EVAL;
          end
        end
        EVAL: begin
          resp_f     <= truth[x_q];
          resp_id    <= id_q;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            served_cnt <= served_cnt + 8'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_func_eval_arbiter.sv
// Scoreboard bench for func_eval_arbiter: directed scenarios then random traffic.
// A negedge monitor predicts grants/results from a round-robin model and checks them.
module tb_func_eval_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_x;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic [IW-1:0]  resp_id;
  logic           resp_f;
  logic           resp_ready;
  logic           cfg_we;
  logic [3:0]     cfg_truth;
  logic           busy;
  logic [7:0]     served_cnt;

  always #5 clk = ~clk;

  func_eval_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_f(resp_f),
    .resp_ready(resp_ready), .cfg_we(cfg_we), .cfg_truth(cfg_truth),
    .busy(busy), .served_cnt(served_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int id;
    int f;
    int gcyc;
  } exp_t;

  exp_t     sbq[$];
  int       glog[$];
  int       flog[$];
  int       cyc = 0;
  int       m_rr;
  bit       m_busy;
  logic [3:0] m_truth;
  int       m_served;
  bit       pend;
  int       p_id, p_x, p_cyc;
  bit       prev_rv;
  bit       stalled;
  int       hold_id, hold_f;

  always @(negedge clk) begin
    int eg;
    logic [N-1:0] exp_rr;
    cyc++;
    if (reset) begin
      sbq.delete();
      pend     = 0;
      m_rr     = 0;
      m_busy   = 0;
      m_truth  = 4'b1011;
      m_served = 0;
      prev_rv  = 0;
      stalled  = 0;
    end else begin
      // result uses the table in force during the cycle after acceptance
      if (pend) begin
        sbq.push_back('{p_id, int'(m_truth >> p_x) & 1, p_cyc});
        pend = 0;
      end
      if (cfg_we) m_truth = cfg_truth;

      exp_rr = '0;
      eg = -1;
      if (!m_busy) begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (m_rr + i) % N;
          if (eg < 0 && req_valid[k]) eg = k;
        end
        if (eg >= 0) exp_rr[eg] = 1'b1;
      end
      chk("req_ready", int'(req_ready), int'(exp_rr));
      chk("busy", int'(busy), int'(m_busy));
      chk("served_cnt", int'(served_cnt), m_served);

      if (eg >= 0) begin
        glog.push_back(eg);
        m_rr   = (eg + 1) % N;
        m_busy = 1;
        pend   = 1;
        p_id   = eg;
        p_x    = int'(req_x >> (2 * eg)) & 3;
        p_cyc  = cyc;
      end

      if (resp_valid) begin
        if (!prev_rv) begin
          chk("resp_expected", int'(sbq.size() > 0), 1);
          if (sbq.size() > 0) begin
            chk("resp_id", int'(resp_id), sbq[0].id);
            chk("resp_f", int'(resp_f), sbq[0].f);
            chk("latency", cyc - sbq[0].gcyc, 2);
          end
        end else if (stalled) begin
          chk("hold_id", int'(resp_id), hold_id);
          chk("hold_f", int'(resp_f), hold_f);
        end
        hold_id = int'(resp_id);
        hold_f  = int'(resp_f);
        stalled = !resp_ready;
        if (resp_ready) begin
          if (sbq.size() > 0) void'(sbq.pop_front());
          flog.push_back(int'(resp_f));
          m_served = (m_served + 1) % 256;
          m_busy   = 0;
        end
      end
      prev_rv = resp_valid;
    end
  end

  // ---------------- stimulus ----------------
  logic [N-1:0] sticky = '0;
  int  ngrant = 0;
  int  limit  = 0;
  bit  rand_mode = 0;

  task automatic step();
    logic [N-1:0] g;
    @(negedge clk);
    g = req_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (g[k]) begin
        ngrant++;
        if (sticky[k]) req_x[2*k +: 2] = 2'($urandom_range(0, 3));
        else req_valid[k] = 1'b0;
      end
    end
    if (sticky != '0 && ngrant >= limit) begin
      req_valid = req_valid & ~sticky;
      sticky = '0;
    end
    if (rand_mode) begin
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
          req_valid[k] = 1'b1;
          req_x[2*k +: 2] = 2'($urandom_range(0, 3));
        end else if (req_valid[k] && $urandom_range(0, 19) == 0) begin
          req_valid[k] = 1'b0;
        end
      end
      resp_ready = 1'($urandom_range(0, 1));
      cfg_we     = ($urandom_range(0, 15) == 0);
      cfg_truth  = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (req_valid == '0 && !busy && !resp_valid) done = 1;
    end
    if (!done) chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int exp2[6];
    int exp3[3];
    int f1[4];
    int nresp;
    bit seen;
    exp2 = '{0, 1, 2, 3, 0, 1};
    exp3 = '{3, 1, 3};
    f1   = '{1, 1, 0, 1};

    reset      = 1'b1;
    req_valid  = '0;
    req_x      = '0;
    resp_ready = 1'b1;
    cfg_we     = 1'b0;
    cfg_truth  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_id", int'(resp_id), 0);
    chk("rst_resp_f", int'(resp_f), 0);
    chk("rst_served", int'(served_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    reset = 1'b0;

    // 1: requester 0 walks the default table
    flog.delete();
    for (int x = 0; x < 4; x++) begin
      req_valid[0] = 1'b1;
      req_x[1:0] = 2'(x);
      wait_idle(20);
    end
    chk("t1_nresp", flog.size(), 4);
    for (int i = 0; i < 4 && i < flog.size(); i++) chk("t1_f", flog[i], f1[i]);
    chk("t1_served", int'(served_cnt), 4);

    // 2: all requesters held valid from a fresh pointer
    do_reset();
    glog.delete();
    ngrant = 0;
    limit  = 6;
    sticky = 4'b1111;
    req_valid = 4'b1111;
    wait_idle(60);
    chk("t2_ngrant", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("t2_order", glog[i], exp2[i]);

    // 3: only 1 and 3, pointer now at 2
    glog.delete();
    ngrant = 0;
    limit  = 3;
    sticky = 4'b1010;
    req_valid = 4'b1010;
    wait_idle(40);
    chk("t3_ngrant", glog.size(), 3);
    for (int i = 0; i < 3 && i < glog.size(); i++) chk("t3_order", glog[i], exp3[i]);

    // 4: backpressure on x=2'b10 with a competing requester waiting
    resp_ready = 1'b0;
    req_valid[2] = 1'b1;
    req_x[5:4] = 2'b10;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = resp_valid;
    end
    chk("t4_resp_seen", int'(seen), 1);
    req_valid[0] = 1'b1;
    req_x[1:0] = 2'b00;
    for (int i = 0; i < 5; i++) step();
    chk("t4_valid", int'(resp_valid), 1);
    chk("t4_f", int'(resp_f), 0);
    chk("t4_id", int'(resp_id), 2);
    resp_ready = 1'b1;
    step();
    chk("t4_served", int'(served_cnt), 10);
    wait_idle(20);
    chk("t4_served2", int'(served_cnt), 11);

    // 5: table write during EVAL takes effect afterwards
    req_valid[1] = 1'b1;
    req_x[3:2] = 2'b10;
    step();
    cfg_we = 1'b1;
    cfg_truth = 4'b0100;
    step();
    cfg_we = 1'b0;
    wait_idle(20);
    chk("t5_old_f", flog[$], 0);
    req_valid[1] = 1'b1;
    req_x[3:2] = 2'b10;
    wait_idle(20);
    chk("t5_new_f", flog[$], 1);

    // 6: reset during EVAL drops the transaction
    nresp = flog.size();
    req_valid[3] = 1'b1;
    req_x[7:6] = 2'b00;
    step();
    #1;
    reset = 1'b1;
    #1;
    chk("t6_resp_valid", int'(resp_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_served", int'(served_cnt), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = '0;
    for (int i = 0; i < 4; i++) step();
    chk("t6_no_resp", flog.size(), nresp);
    req_valid[0] = 1'b1;
    req_x[1:0] = 2'b00;
    wait_idle(20);
    chk("t6_truth_rst", flog[$], 1);

    // random traffic
    rand_mode = 1;
    for (int i = 0; i < 1500; i++) step();
    rand_mode = 0;
    cfg_we = 1'b0;
    resp_ready = 1'b1;
    req_valid = '0;
    wait_idle(20);
    chk("drain_sb_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
